// File: rtl/muldiv_pkg.sv
// Shared types and constants for the muldiv scheduler: funct3 encodings,
// tracker/response records and the unit latency helper.
package muldiv_pkg;

    localparam int unsigned MD_XLEN  = 32;
    localparam int unsigned MD_TAG_W = 5;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        FUNCT3_MUL    = 3'd0,
        FUNCT3_MULH   = 3'd1,
        FUNCT3_MULHSU = 3'd2,
        FUNCT3_MULHU  = 3'd3,
        FUNCT3_DIV    = 3'd4,
        FUNCT3_DIVU   = 3'd5,
        FUNCT3_REM    = 3'd6,
        FUNCT3_REMU   = 3'd7
    } md_funct3_e;

    typedef struct packed {
        logic                valid;
        logic                id;
        logic [MD_TAG_W-1:0] tag;
    } md_trk_t;

    typedef struct packed {
        logic                id;
        logic [MD_TAG_W-1:0] tag;
        logic [MD_XLEN-1:0]  data;
    } md_rsp_t;

    function automatic int unsigned md_latency(input int unsigned num_stage);
        return num_stage - 1;
    endfunction

endpackage

// File: rtl/muldiv_rsp_fifo.sv
// Shift-register response FIFO; entry 0 is always the head, so the head is
// read straight from a register. Simultaneous push and pop are allowed when full.
module muldiv_rsp_fifo
    import muldiv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  md_rsp_t push_data_i,
    input  logic    pop_i,
    output logic    empty_o,
    output logic    full_o,
    output md_rsp_t head_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    md_rsp_t          mem [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] wr_idx;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign head_o  = mem[0];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    // A pop shifts everything down one slot, so the write lands one lower.
    assign wr_idx  = count - CNT_W'(pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (push_ok && (wr_idx == CNT_W'(i))) begin
                    mem[i] <= push_data_i;
                end else if (pop_ok && (i + 1 < DEPTH)) begin
                    mem[i] <= mem[(i + 1 < DEPTH) ? i + 1 : i];
                end
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Round-robin scheduler sharing one pipelined muldiv unit between two requesters,
// with credit-guarded response buffering. Optional perf counters: MULDIV_SCHED_PERF_EN.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_STAGE = 2,
    parameter int unsigned TAG_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [XLEN-1:0]  req0_a_i,
    input  logic [XLEN-1:0]  req0_b_i,
    input  logic [2:0]       req0_funct3_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [XLEN-1:0]  req1_a_i,
    input  logic [XLEN-1:0]  req1_b_i,
    input  logic [2:0]       req1_funct3_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    output logic [XLEN-1:0]  md_a_o,
    output logic [XLEN-1:0]  md_b_o,
    output logic [6:0]       md_opcode_o,
    output logic [6:0]       md_funct7_o,
    output logic [2:0]       md_funct3_o,
    input  logic [XLEN-1:0]  md_result_i,
    input  logic             md_valid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [XLEN-1:0]  rsp_data_o
`ifdef MULDIV_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issue_o,
    output logic [31:0]      perf_stall_o
`endif
);

    localparam int unsigned L          = md_latency(NUM_STAGE);
    localparam int unsigned CREDIT_MAX = L + 1;
    localparam int unsigned CW         = $clog2(CREDIT_MAX + 1);

    logic          last_grant;
    logic          grant1;
    logic          any_valid;
    logic          can_issue;
    logic          iss;
    logic          iss_out;
    logic          rsp_hs;
    logic [CW-1:0] credits;
    md_trk_t       trk [L];
    md_trk_t       trk_tail;
    md_rsp_t       fifo_head;
    md_rsp_t       push_data;
    logic          fifo_empty;
    logic          fifo_full;

    // last_grant resets to 1 so req0 wins the first contested cycle.
    assign any_valid = req0_valid_i | req1_valid_i;
    assign grant1    = req1_valid_i & (~req0_valid_i | ~last_grant);
    assign rsp_hs    = rsp_valid_o & rsp_ready_i;
    assign can_issue = (credits < CW'(CREDIT_MAX)) | rsp_hs;
    assign iss       = can_issue & any_valid;
    assign iss_out   = iss & rst_ni;

    assign req0_ready_o = iss_out & ~grant1;
    assign req1_ready_o = iss_out & grant1;

    always_comb begin
        md_a_o      = '0;
        md_b_o      = '0;
        md_opcode_o = '0;
        md_funct7_o = '0;
        md_funct3_o = '0;
        if (iss_out) begin
            md_a_o      = grant1 ? req1_a_i : req0_a_i;
            md_b_o      = grant1 ? req1_b_i : req0_b_i;
            md_funct3_o = grant1 ? req1_funct3_i : req0_funct3_i;
            md_opcode_o = OPCODE_R;
            md_funct7_o = FUNCT7_MULDIV;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= 1'b1;
            credits    <= '0;
            for (int unsigned i = 0; i < L; i++) begin
                trk[i] <= '0;
            end
        end else begin
            if (iss) begin
                last_grant <= grant1;
            end
            unique case ({iss, rsp_hs})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
            trk[0] <= '{valid: iss, id: grant1, tag: grant1 ? req1_tag_i : req0_tag_i};
            for (int unsigned i = 1; i < L; i++) begin
                trk[i] <= trk[i-1];
            end
        end
    end

    assign trk_tail  = trk[L-1];
    assign push_data = '{id: trk_tail.id, tag: trk_tail.tag, data: md_result_i};

    muldiv_rsp_fifo #(
        .DEPTH (CREDIT_MAX)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (trk_tail.valid),
        .push_data_i (push_data),
        .pop_i       (rsp_hs),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .head_o      (fifo_head)
    );

    assign rsp_valid_o = ~fifo_empty;
    assign rsp_id_o    = fifo_head.id;
    assign rsp_tag_o   = fifo_head.tag;
    assign rsp_data_o  = fifo_head.data;

    trk_sync_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        trk_tail.valid == md_valid_i);

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(trk_tail.valid && fifo_full && !rsp_hs));

`ifdef MULDIV_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issue_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (iss && (perf_issue_o != '1)) begin
                perf_issue_o <= perf_issue_o + 32'd1;
            end
            if (any_valid && !can_issue && (perf_stall_o != '1)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched with a behavioural muldiv unit
// of latency NUM_STAGE-1 attached to the md_* interface.
module tb_muldiv_sched;

    localparam int NUM_STAGE = 2;
    localparam int LAT       = NUM_STAGE - 1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic [2:0]  req0_funct3_i, req1_funct3_i;
    logic [4:0]  req0_tag_i, req1_tag_i;
    logic [31:0] md_a_o, md_b_o, md_result_i;
    logic [6:0]  md_opcode_o, md_funct7_o;
    logic [2:0]  md_funct3_o;
    logic        md_valid_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [4:0]  rsp_tag_o;
    logic [31:0] rsp_data_o;

    int checks = 0;
    int errors = 0;

    logic        q_id   [$];
    logic [4:0]  q_tag  [$];
    logic [31:0] q_data [$];

    muldiv_sched #(
        .XLEN      (32),
        .NUM_STAGE (NUM_STAGE),
        .TAG_W     (5)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_a_i      (req0_a_i),
        .req0_b_i      (req0_b_i),
        .req0_funct3_i (req0_funct3_i),
        .req0_tag_i    (req0_tag_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_a_i      (req1_a_i),
        .req1_b_i      (req1_b_i),
        .req1_funct3_i (req1_funct3_i),
        .req1_tag_i    (req1_tag_i),
        .md_a_o        (md_a_o),
        .md_b_o        (md_b_o),
        .md_opcode_o   (md_opcode_o),
        .md_funct7_o   (md_funct7_o),
        .md_funct3_o   (md_funct3_o),
        .md_result_i   (md_result_i),
        .md_valid_i    (md_valid_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_tag_o     (rsp_tag_o),
        .rsp_data_o    (rsp_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural muldiv unit following RISC-V M-extension semantics.
    function automatic logic [31:0] unit_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    logic        pv [LAT];
    logic [31:0] pd [LAT];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 32'd0;
            end
        end else begin
            pv[0] <= (md_opcode_o == 7'h33);
            pd[0] <= unit_calc(md_funct3_o, md_a_o, md_b_o);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign md_valid_i  = pv[LAT-1];
    assign md_result_i = pd[LAT-1];

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic sample_rsp();
        if (rsp_valid_o && rsp_ready_i) begin
            q_id.push_back(rsp_id_o);
            q_tag.push_back(rsp_tag_o);
            q_data.push_back(rsp_data_o);
        end
    endtask

    task automatic clear_q();
        q_id.delete();
        q_tag.delete();
        q_data.delete();
    endtask

    task automatic idle_reqs();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req0_valid_i = 1'b1; req0_a_i = 32'd5; req0_b_i = 32'd5; req0_funct3_i = 3'd0; req0_tag_i = 5'd1;
        req1_valid_i = 1'b1; req1_a_i = 32'd5; req1_b_i = 32'd5; req1_funct3_i = 3'd0; req1_tag_i = 5'd2;
        rsp_ready_i = 1'b1;
        next_cycle();
        #1;
        checks++; if (req0_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready_o); end
        checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", req1_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (md_opcode_o !== 7'd0 || md_funct7_o !== 7'd0) begin errors++; $display("FAIL reset_md_op: got %h/%h expected 0/0", md_opcode_o, md_funct7_o); end
        checks++; if (md_a_o !== 32'd0 || md_b_o !== 32'd0) begin errors++; $display("FAIL reset_md_ab: got %h/%h expected 0/0", md_a_o, md_b_o); end
        checks++; if (rsp_data_o !== 32'd0 || rsp_tag_o !== 5'd0 || rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_fields: got %h/%h/%b expected 0", rsp_data_o, rsp_tag_o, rsp_id_o); end
        idle_reqs();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic        exp_id   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0]  exp_tag  [8] = '{5'd0, 5'd16, 5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19};
        logic [31:0] exp_data [8] = '{32'd2, 32'd3, 32'd4, 32'd6, 32'd6, 32'd9, 32'd8, 32'd12};
        int cnt0 = 0;
        int cnt1 = 0;
        logic        gid;
        logic [4:0]  gtag;
        logic [31:0] gdata;
        clear_q();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_valid_i = 1'b1; req0_a_i = 32'(cnt0 + 1); req0_b_i = 32'd2; req0_funct3_i = 3'd0; req0_tag_i = 5'(cnt0);
            req1_valid_i = 1'b1; req1_a_i = 32'(cnt1 + 1); req1_b_i = 32'd3; req1_funct3_i = 3'd0; req1_tag_i = 5'(16 + cnt1);
            #1;
            checks++; if (req0_ready_o !== exp_id[i] ? 1'b0 : 1'b1) begin errors++; $display("FAIL rr_grant0[%0d]: got %b expected %b", i, req0_ready_o, !exp_id[i]); end
            checks++; if (req1_ready_o !== exp_id[i]) begin errors++; $display("FAIL rr_grant1[%0d]: got %b expected %b", i, req1_ready_o, exp_id[i]); end
            if (req0_ready_o) cnt0++;
            if (req1_ready_o) cnt1++;
            sample_rsp();
            next_cycle();
        end
        idle_reqs();
        for (int i = 0; i < 6; i++) begin
            #1; sample_rsp(); next_cycle();
        end
        checks++; if (q_tag.size() != 8) begin errors++; $display("FAIL rr_rsp_count: got %0d expected 8", q_tag.size()); end
        for (int k = 0; k < 8; k++) begin
            gid   = (k < q_id.size())   ? q_id[k]   : 1'bx;
            gtag  = (k < q_tag.size())  ? q_tag[k]  : 5'bx;
            gdata = (k < q_data.size()) ? q_data[k] : 32'bx;
            checks++; if (gid !== exp_id[k] || gtag !== exp_tag[k] || gdata !== exp_data[k]) begin
                errors++; $display("FAIL rr_rsp[%0d]: got id %b tag %0d data %0d expected id %b tag %0d data %0d", k, gid, gtag, gdata, exp_id[k], exp_tag[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_single_mul();
        rsp_ready_i = 1'b1;
        req0_valid_i = 1'b1; req0_a_i = 32'd7; req0_b_i = 32'd6; req0_funct3_i = 3'd0; req0_tag_i = 5'd3;
        #1;
        checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL mul_issue_ready: got %b expected 1", req0_ready_o); end
        checks++; if (md_opcode_o !== 7'h33 || md_funct7_o !== 7'h01 || md_funct3_o !== 3'd0) begin errors++; $display("FAIL mul_md_ctrl: got %h/%h/%h expected 33/01/0", md_opcode_o, md_funct7_o, md_funct3_o); end
        checks++; if (md_a_o !== 32'd7 || md_b_o !== 32'd6) begin errors++; $display("FAIL mul_md_ops: got %0d/%0d expected 7/6", md_a_o, md_b_o); end
        next_cycle();
        idle_reqs();
        for (int k = 1; k <= LAT; k++) begin
            #1;
            checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mul_early_rsp[%0d]: got %b expected 0", k, rsp_valid_o); end
            checks++; if (md_opcode_o !== 7'd0) begin errors++; $display("FAIL mul_idle_opcode[%0d]: got %h expected 0", k, md_opcode_o); end
            next_cycle();
        end
        #1;
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mul_rsp_valid: got %b expected 1", rsp_valid_o); end
        checks++; if (rsp_data_o !== 32'd42 || rsp_id_o !== 1'b0 || rsp_tag_o !== 5'd3) begin errors++; $display("FAIL mul_rsp_fields: got data %0d id %b tag %0d expected 42 0 3", rsp_data_o, rsp_id_o, rsp_tag_o); end
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mul_rsp_pop: got %b expected 0", rsp_valid_o); end
        next_cycle();
    endtask

    task automatic test_back_pressure();
        int acc = 0;
        logic [4:0]  gtag;
        logic [31:0] gdata;
        logic        gid;
        clear_q();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_valid_i = 1'b1; req0_a_i = 32'(10 + acc); req0_b_i = 32'd1; req0_funct3_i = 3'd0; req0_tag_i = 5'(8 + acc);
            #1;
            checks++; if (req0_ready_o !== ((i < LAT + 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected %b", i, req0_ready_o, (i < LAT + 1)); end
            if (req0_ready_o) acc++;
            next_cycle();
        end
        checks++; if (acc != LAT + 1) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, LAT + 1); end
        idle_reqs();
        next_cycle();
        #1;
        checks++; if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 5'd8) begin errors++; $display("FAIL bp_head_held: got valid %b tag %0d expected 1 8", rsp_valid_o, rsp_tag_o); end
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; sample_rsp(); next_cycle();
        end
        checks++; if (q_tag.size() != 2) begin errors++; $display("FAIL bp_rsp_count: got %0d expected 2", q_tag.size()); end
        for (int k = 0; k < 2; k++) begin
            gid   = (k < q_id.size())   ? q_id[k]   : 1'bx;
            gtag  = (k < q_tag.size())  ? q_tag[k]  : 5'bx;
            gdata = (k < q_data.size()) ? q_data[k] : 32'bx;
            checks++; if (gid !== 1'b0 || gtag !== 5'(8 + k) || gdata !== 32'(10 + k)) begin
                errors++; $display("FAIL bp_rsp[%0d]: got id %b tag %0d data %0d expected 0 %0d %0d", k, gid, gtag, gdata, 8 + k, 10 + k);
            end
        end
    endtask

    task automatic test_div_corner();
        logic        gid;
        logic [4:0]  gtag;
        logic [31:0] gdata;
        logic        exp_id   [2] = '{1'b0, 1'b1};
        logic [4:0]  exp_tag  [2] = '{5'd5, 5'd9};
        logic [31:0] exp_data [2] = '{32'h8000_0000, 32'hFFFF_FFFF};
        clear_q();
        rsp_ready_i = 1'b1;
        req0_valid_i = 1'b1; req0_a_i = 32'h8000_0000; req0_b_i = 32'hFFFF_FFFF; req0_funct3_i = 3'd4; req0_tag_i = 5'd5;
        #1;
        checks++; if (req0_ready_o !== 1'b1 || md_funct3_o !== 3'd4) begin errors++; $display("FAIL div_issue: got ready %b funct3 %0d expected 1 4", req0_ready_o, md_funct3_o); end
        next_cycle();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_a_i = 32'd5; req1_b_i = 32'd0; req1_funct3_i = 3'd5; req1_tag_i = 5'd9;
        #1;
        checks++; if (req1_ready_o !== 1'b1 || md_funct3_o !== 3'd5 || md_a_o !== 32'd5) begin errors++; $display("FAIL divu_issue: got ready %b funct3 %0d a %0d expected 1 5 5", req1_ready_o, md_funct3_o, md_a_o); end
        sample_rsp();
        next_cycle();
        idle_reqs();
        for (int i = 0; i < 5; i++) begin
            #1; sample_rsp(); next_cycle();
        end
        checks++; if (q_tag.size() != 2) begin errors++; $display("FAIL div_rsp_count: got %0d expected 2", q_tag.size()); end
        for (int k = 0; k < 2; k++) begin
            gid   = (k < q_id.size())   ? q_id[k]   : 1'bx;
            gtag  = (k < q_tag.size())  ? q_tag[k]  : 5'bx;
            gdata = (k < q_data.size()) ? q_data[k] : 32'bx;
            checks++; if (gid !== exp_id[k] || gtag !== exp_tag[k] || gdata !== exp_data[k]) begin
                errors++; $display("FAIL div_rsp[%0d]: got id %b tag %0d data %h expected %b %0d %h", k, gid, gtag, gdata, exp_id[k], exp_tag[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        logic [4:0] gtag;
        clear_q();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0_valid_i = 1'b1; req0_a_i = 32'(i + 1); req0_b_i = 32'd1; req0_funct3_i = 3'd0; req0_tag_i = 5'(1 + i);
            #1;
            checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL mf_issue[%0d]: got %b expected 1", i, req0_ready_o); end
            next_cycle();
        end
        req0_tag_i = 5'd3;
        rst_ni = 1'b0;
        #1;
        checks++; if (rsp_valid_o !== 1'b0 || rsp_tag_o !== 5'd0 || rsp_data_o !== 32'd0) begin errors++; $display("FAIL mf_rst_rsp: got valid %b tag %0d data %0d expected 0", rsp_valid_o, rsp_tag_o, rsp_data_o); end
        checks++; if (req0_ready_o !== 1'b0 || md_opcode_o !== 7'd0) begin errors++; $display("FAIL mf_rst_issue: got ready %b opcode %h expected 0", req0_ready_o, md_opcode_o); end
        next_cycle();
        next_cycle();
        idle_reqs();
        rst_ni = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mf_stale_rsp[%0d]: got %b expected 0", i, rsp_valid_o); end
            next_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            req0_valid_i = 1'b1; req0_a_i = 32'd1; req0_b_i = 32'd1; req0_funct3_i = 3'd0; req0_tag_i = 5'(24 + acc);
            #1;
            if (req0_ready_o) acc++;
            next_cycle();
        end
        checks++; if (acc != LAT + 1) begin errors++; $display("FAIL mf_credits_cleared: got %0d accepted expected %0d", acc, LAT + 1); end
        idle_reqs();
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; sample_rsp(); next_cycle();
        end
        checks++; if (q_tag.size() != 2) begin errors++; $display("FAIL mf_rsp_count: got %0d expected 2", q_tag.size()); end
        gtag = (q_tag.size() > 0) ? q_tag[0] : 5'bx;
        checks++; if (gtag !== 5'd24) begin errors++; $display("FAIL mf_first_tag: got %0d expected 24", gtag); end
    endtask

    task automatic test_issue_with_pop();
        logic [4:0]  gtag;
        logic [31:0] gdata;
        clear_q();
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req0_valid_i = 1'b1; req0_a_i = 32'(i + 1); req0_b_i = 32'd100; req0_funct3_i = 3'd0; req0_tag_i = 5'(20 + i);
            #1;
            checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL pop_fill[%0d]: got %b expected 1", i, req0_ready_o); end
            next_cycle();
        end
        idle_reqs();
        next_cycle();
        next_cycle();
        req0_valid_i = 1'b1; req0_a_i = 32'd3; req0_b_i = 32'd100; req0_funct3_i = 3'd0; req0_tag_i = 5'd22;
        rsp_ready_i = 1'b1;
        #1;
        checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL pop_same_cycle_issue: got %b expected 1", req0_ready_o); end
        checks++; if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 5'd20) begin errors++; $display("FAIL pop_head: got valid %b tag %0d expected 1 20", rsp_valid_o, rsp_tag_o); end
        sample_rsp();
        next_cycle();
        req0_a_i = 32'd4; req0_tag_i = 5'd23;
        rsp_ready_i = 1'b0;
        #1;
        checks++; if (req0_ready_o !== 1'b0) begin errors++; $display("FAIL pop_credits_full: got %b expected 0", req0_ready_o); end
        next_cycle();
        rsp_ready_i = 1'b1;
        #1;
        checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL pop_full_issue: got %b expected 1", req0_ready_o); end
        sample_rsp();
        next_cycle();
        idle_reqs();
        for (int i = 0; i < 5; i++) begin
            #1; sample_rsp(); next_cycle();
        end
        checks++; if (q_tag.size() != 4) begin errors++; $display("FAIL pop_rsp_count: got %0d expected 4", q_tag.size()); end
        for (int k = 0; k < 4; k++) begin
            gtag  = (k < q_tag.size())  ? q_tag[k]  : 5'bx;
            gdata = (k < q_data.size()) ? q_data[k] : 32'bx;
            checks++; if (gtag !== 5'(20 + k) || gdata !== 32'(100 * (k + 1))) begin
                errors++; $display("FAIL pop_rsp[%0d]: got tag %0d data %0d expected %0d %0d", k, gtag, gdata, 20 + k, 100 * (k + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_mul();
        test_back_pressure();
        test_div_corner();
        test_reset_midflight();
        test_issue_with_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
